// File: rtl/uncache_handler.sv
// Uncached access engine: issues committed uncached stores and uncached loads
// on one single-outstanding AXI-lite-style port, one transaction at a time.
module uncache_handler #(
  parameter int ID_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  // write buffer head
  input  logic            wb_w,
  input  logic [31:0]     wb_waddr,
  input  logic [31:0]     wb_data,
  input  logic [1:0]      wb_size,
  output logic            wb_ready,
  // load path
  input  logic            ld_req,
  input  logic [31:0]     ld_addr,
  input  logic [1:0]      ld_size,
  input  logic [ID_W-1:0] ld_id,
  output logic            ld_ready,
  output logic            ld_valid,
  output logic [31:0]     ld_data,
  output logic [ID_W-1:0] ld_rid,
  input  logic            flush,
  output logic            busy,
  // memory port
  output logic            awvalid,
  output logic [31:0]     awaddr,
  output logic [1:0]      awsize,
  input  logic            awready,
  output logic            wvalid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready,
  output logic            arvalid,
  output logic [31:0]     araddr,
  output logic [1:0]      arsize,
  input  logic            arready,
  input  logic            rvalid,
  input  logic [31:0]     rdata,
  output logic            rready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_REQ  = 3'd1,
    W_RESP = 3'd2,
    R_REQ  = 3'd3,
    R_DATA = 3'd4,
    R_DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            kill_q, kill_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      size_q, size_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     rdata_q, rdata_d;

  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'hF;
    endcase
    return s;
  endfunction

  // Narrow stores are replicated across all lanes; wstrb selects the live one.
  function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {lo, 3'b000};
    case (size)
      2'd0:    r = {24'h0, sh[7:0]};
      2'd1:    r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    id_d      = id_q;
    rdata_d   = rdata_q;

    wb_ready  = 1'b0;
    ld_ready  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 32'h0;
    ld_rid    = '0;
    awvalid   = 1'b0;
    awaddr    = 32'h0;
    awsize    = 2'd0;
    wvalid    = 1'b0;
    wdata     = 32'h0;
    wstrb     = 4'h0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    araddr    = 32'h0;
    arsize    = 2'd0;
    rready    = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (wb_w) begin
          addr_d    = wb_waddr;
          data_d    = wb_data;
          size_d    = wb_size;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = W_REQ;
        end else if (ld_req && !flush) begin
          ld_ready = 1'b1;
          addr_d   = ld_addr;
          size_d   = ld_size;
          id_d     = ld_id;
          kill_d   = 1'b0;
          state_d  = R_REQ;
        end
      end

      // Address and data channels complete independently, in either order.
      W_REQ: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        awaddr  = addr_q;
        awsize  = size_q;
        wdata   = store_wdata(size_q, data_q);
        wstrb   = store_strb(size_q, addr_q[1:0]);
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = W_RESP;
      end

      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          wb_ready = 1'b1;
          state_d  = IDLE;
        end
      end

      R_REQ: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        arsize  = size_q;
        if (flush)   kill_d  = 1'b1;
        if (arready) state_d = R_DATA;
      end

      R_DATA: begin
        rready = 1'b1;
        if (flush) kill_d = 1'b1;
        if (rvalid) begin
          rdata_d = load_extract(rdata, addr_q[1:0], size_q);
          state_d = R_DONE;
        end
      end

      // A rollback arriving in the return cycle still drops the result.
      R_DONE: begin
        if (flush) kill_d = 1'b1;
        if (!kill_q && !flush) begin
          ld_valid = 1'b1;
          ld_data  = rdata_q;
          ld_rid   = id_q;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kill_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Request payload is only observed through state-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    data_q  <= data_d;
    size_q  <= size_d;
    id_q    <= id_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_uncache_handler.sv
// Directed bench for uncache_handler: stores, loads, flush, priority and reset.
module tb_uncache_handler;
  localparam int ID_W = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_w;
  logic [31:0]     wb_waddr;
  logic [31:0]     wb_data;
  logic [1:0]      wb_size;
  logic            wb_ready;
  logic            ld_req;
  logic [31:0]     ld_addr;
  logic [1:0]      ld_size;
  logic [ID_W-1:0] ld_id;
  logic            ld_ready;
  logic            ld_valid;
  logic [31:0]     ld_data;
  logic [ID_W-1:0] ld_rid;
  logic            flush;
  logic            busy;
  logic            awvalid;
  logic [31:0]     awaddr;
  logic [1:0]      awsize;
  logic            awready;
  logic            wvalid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wready;
  logic            bvalid;
  logic            bready;
  logic            arvalid;
  logic [31:0]     araddr;
  logic [1:0]      arsize;
  logic            arready;
  logic            rvalid;
  logic [31:0]     rdata;
  logic            rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uncache_handler #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .wb_w(wb_w), .wb_waddr(wb_waddr), .wb_data(wb_data), .wb_size(wb_size),
    .wb_ready(wb_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_id(ld_id),
    .ld_ready(ld_ready), .ld_valid(ld_valid), .ld_data(ld_data), .ld_rid(ld_rid),
    .flush(flush), .busy(busy),
    .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1ns after the edge, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_w = 1'b0; wb_waddr = 32'h0; wb_data = 32'h0; wb_size = 2'd0;
    ld_req = 1'b0; ld_addr = 32'h0; ld_size = 2'd0; ld_id = '0; flush = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = 32'h0;
    tick(); tick();
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    rst = 1'b0;

    // Word store
    tick();
    wb_w = 1'b1; wb_waddr = 32'h1FC0_0004; wb_data = 32'hDEAD_BEEF; wb_size = 2'd2;
    settle();
    check("ws_idle_wb_ready", 32'(wb_ready), 32'd0);
    tick();
    awready = 1'b1; wready = 1'b1;
    settle();
    check("ws_awvalid", 32'(awvalid), 32'd1);
    check("ws_wvalid", 32'(wvalid), 32'd1);
    check("ws_awaddr", awaddr, 32'h1FC0_0004);
    check("ws_awsize", 32'(awsize), 32'd2);
    check("ws_wstrb", 32'(wstrb), 32'hF);
    check("ws_wdata", wdata, 32'hDEAD_BEEF);
    check("ws_busy", 32'(busy), 32'd1);
    tick();
    awready = 1'b0; wready = 1'b0;
    settle();
    check("ws_resp_bready", 32'(bready), 32'd1);
    check("ws_resp_awvalid", 32'(awvalid), 32'd0);
    check("ws_resp_wvalid", 32'(wvalid), 32'd0);
    check("ws_wait_wb_ready", 32'(wb_ready), 32'd0);
    tick();
    bvalid = 1'b1;
    settle();
    check("ws_wb_ready", 32'(wb_ready), 32'd1);
    tick();
    bvalid = 1'b0; wb_w = 1'b0;
    settle();
    check("ws_after_wb_ready", 32'(wb_ready), 32'd0);
    check("ws_after_busy", 32'(busy), 32'd0);

    // Byte store, data channel completes three cycles before address channel
    wb_w = 1'b1; wb_waddr = 32'h1FC0_0003; wb_data = 32'h0000_00A5; wb_size = 2'd0;
    tick();
    wready = 1'b1;
    settle();
    check("bs_wstrb", 32'(wstrb), 32'h8);
    check("bs_wdata", wdata, 32'hA5A5_A5A5);
    check("bs_awvalid0", 32'(awvalid), 32'd1);
    check("bs_wvalid0", 32'(wvalid), 32'd1);
    tick();
    wready = 1'b0;
    settle();
    check("bs_wvalid_drop", 32'(wvalid), 32'd0);
    check("bs_awvalid1", 32'(awvalid), 32'd1);
    tick();
    settle();
    check("bs_awvalid2", 32'(awvalid), 32'd1);
    check("bs_bready_early", 32'(bready), 32'd0);
    tick();
    awready = 1'b1;
    settle();
    check("bs_awvalid3", 32'(awvalid), 32'd1);
    check("bs_awaddr", awaddr, 32'h1FC0_0003);
    tick();
    awready = 1'b0; bvalid = 1'b1;
    settle();
    check("bs_awvalid_drop", 32'(awvalid), 32'd0);
    check("bs_wb_ready", 32'(wb_ready), 32'd1);
    tick();
    bvalid = 1'b0; wb_w = 1'b0;
    settle();
    check("bs_idle", 32'(busy), 32'd0);

    // Halfword load from offset 2
    ld_req = 1'b1; ld_addr = 32'h1FC0_0002; ld_size = 2'd1; ld_id = 7'h15;
    settle();
    check("ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_req = 1'b0; arready = 1'b1;
    settle();
    check("ld_arvalid", 32'(arvalid), 32'd1);
    check("ld_araddr", araddr, 32'h1FC0_0002);
    check("ld_arsize", 32'(arsize), 32'd1);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    settle();
    check("ld_arvalid_drop", 32'(arvalid), 32'd0);
    check("ld_rready", 32'(rready), 32'd1);
    check("ld_valid_early", 32'(ld_valid), 32'd0);
    tick();
    rvalid = 1'b0;
    settle();
    check("ld_valid", 32'(ld_valid), 32'd1);
    check("ld_data", ld_data, 32'h0000_1234);
    check("ld_rid", 32'(ld_rid), 32'h15);
    tick();
    settle();
    check("ld_valid_pulse", 32'(ld_valid), 32'd0);
    check("ld_idle", 32'(busy), 32'd0);

    // Load flushed one cycle after arready
    ld_req = 1'b1; ld_addr = 32'h1FC0_0000; ld_size = 2'd2; ld_id = 7'h2A;
    settle();
    check("fl_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; flush = 1'b1;
    settle();
    check("fl_rready0", 32'(rready), 32'd1);
    tick();
    flush = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    settle();
    check("fl_rready1", 32'(rready), 32'd1);
    tick();
    rvalid = 1'b0;
    settle();
    check("fl_ld_valid", 32'(ld_valid), 32'd0);
    check("fl_busy_done", 32'(busy), 32'd1);
    tick();
    settle();
    check("fl_ld_valid_after", 32'(ld_valid), 32'd0);
    check("fl_idle", 32'(busy), 32'd0);

    // Flush in IDLE blocks that cycle's load
    ld_req = 1'b1; flush = 1'b1;
    settle();
    check("fl_idle_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    ld_req = 1'b0; flush = 1'b0;
    settle();
    check("fl_idle_busy", 32'(busy), 32'd0);

    // Store beats a simultaneous load
    wb_w = 1'b1; wb_waddr = 32'h1FC0_0010; wb_data = 32'h1122_3344; wb_size = 2'd2;
    ld_req = 1'b1; ld_addr = 32'h1FC0_0001; ld_size = 2'd0; ld_id = 7'h7F;
    settle();
    check("pr_ld_ready0", 32'(ld_ready), 32'd0);
    tick();
    awready = 1'b1; wready = 1'b1;
    settle();
    check("pr_awaddr", awaddr, 32'h1FC0_0010);
    check("pr_arvalid", 32'(arvalid), 32'd0);
    check("pr_ld_ready1", 32'(ld_ready), 32'd0);
    tick();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    settle();
    check("pr_wb_ready", 32'(wb_ready), 32'd1);
    check("pr_ld_ready2", 32'(ld_ready), 32'd0);
    tick();
    bvalid = 1'b0; wb_w = 1'b0;
    settle();
    check("pr_ld_ready3", 32'(ld_ready), 32'd1);
    tick();
    ld_req = 1'b0; arready = 1'b1;
    settle();
    check("pr_araddr", araddr, 32'h1FC0_0001);
    check("pr_arsize", 32'(arsize), 32'd0);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hAABB_CCDD;
    tick();
    rvalid = 1'b0;
    settle();
    check("pr_ld_valid", 32'(ld_valid), 32'd1);
    check("pr_ld_data", ld_data, 32'h0000_00CC);
    check("pr_ld_rid", 32'(ld_rid), 32'h7F);
    tick();
    settle();
    check("pr_idle", 32'(busy), 32'd0);

    // Upper-half store, then reset while waiting for the response
    wb_w = 1'b1; wb_waddr = 32'h1FC0_0022; wb_data = 32'h0000_BEEF; wb_size = 2'd1;
    tick();
    awready = 1'b1; wready = 1'b1;
    settle();
    check("rs_wstrb", 32'(wstrb), 32'hC);
    check("rs_wdata", wdata, 32'hBEEF_BEEF);
    tick();
    awready = 1'b0; wready = 1'b0; rst = 1'b1; wb_w = 1'b0;
    settle();
    check("rs_bready", 32'(bready), 32'd1);
    check("rs_wb_ready0", 32'(wb_ready), 32'd0);
    tick();
    rst = 1'b0; bvalid = 1'b1;
    settle();
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_awvalid", 32'(awvalid), 32'd0);
    check("rs_wvalid", 32'(wvalid), 32'd0);
    check("rs_bready_off", 32'(bready), 32'd0);
    check("rs_wb_ready1", 32'(wb_ready), 32'd0);
    tick();
    bvalid = 1'b0;
    settle();
    check("rs_wb_ready2", 32'(wb_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
